mc_cpu: RTL and testbench

MC_CPU -- requirements
Module: mc_cpu

---
 rtl/mc_cpu.sv | 141 ++++++++++++++
 tb/tb_mc_cpu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle, non-pipelined MIPS-subset core with one unified memory port.
// FETCH/DECODE/EXEC/MEM/WB sequencing; illegal instructions park the core in HALT until reset.
module mc_cpu #(
    parameter int          ADDR_W   = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              Clk,
    input  logic              Clrn,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halt
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    state_t      st, st_nx;
    logic        active;
    logic [31:0] ir, a, b, aluout, mdr;
    logic [31:0] rf [32];
    logic [5:0]  op, fn, alu_op;
    logic [4:0]  rs, rt, rd, wa;
    logic [31:0] sext, zext, opb, alu_res, jt, br_off, wd;
    logic        is_r, is_imm, is_ldst, is_br, legal, taken, acc;
    logic        unused_bits;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign fn      = ir[5:0];
    assign sext    = {{16{ir[15]}}, ir[15:0]};
    assign zext    = {16'h0, ir[15:0]};
    assign jt      = {4'h0, ir[25:0], 2'b00};
    assign br_off  = {sext[29:0], 2'b00};
    assign is_r    = op == OP_R;
    assign is_imm  = op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
    assign is_ldst = op == OP_LW || op == OP_SW;
    assign is_br   = op == OP_BEQ || op == OP_BNE;
    assign legal   = is_r ? (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT)
                          : (is_imm || is_ldst || is_br || op == OP_J);

    // Immediate forms reuse the R-type funct encoding to select the ALU operation
    assign alu_op  = is_r ? fn : op == OP_ANDI ? FN_AND : op == OP_ORI ? FN_OR : FN_ADD;
    assign opb     = is_r ? b : (op == OP_ANDI || op == OP_ORI) ? zext : sext;
    assign alu_res = alu_op == FN_SUB ? a - opb :
                     alu_op == FN_AND ? a & opb :
                     alu_op == FN_OR  ? a | opb :
                     alu_op == FN_SLT ? {31'h0, $signed(a) < $signed(opb)} : a + opb;
    assign taken   = (op == OP_BEQ) == (a == b);
    assign wa      = is_r ? rd : rt;
    assign wd      = op == OP_LW ? mdr : aluout;

    // active holds the request low until the first edge after reset release
    assign mem_req   = active && (st == FETCH || st == MEM);
    assign acc       = mem_req && mem_ack;
    assign mem_we    = mem_req && st == MEM && op == OP_SW;
    assign mem_addr  = st == MEM ? {aluout[ADDR_W-1:2], 2'b00} : pc;
    assign mem_wdata = (st == MEM && op == OP_SW) ? b : '0;
    assign state     = st;
    assign halt      = st == HALT;

    assign unused_bits = ^{ir[10:6], jt, br_off, aluout};

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) st <= FETCH;
        else       st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            FETCH:   st_nx = acc ? DECODE : FETCH;
            DECODE:  st_nx = !legal ? HALT : op == OP_J ? FETCH : EXEC;
            EXEC:    st_nx = is_br ? FETCH : is_ldst ? MEM : WB;
            MEM:     st_nx = !acc ? MEM : op == OP_LW ? WB : FETCH;
            WB:      st_nx = FETCH;
            default: st_nx = HALT;
        endcase
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            active <= 1'b0;
            pc     <= RESET_PC[ADDR_W-1:0];
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            active <= 1'b1;
            case (st)
                FETCH: if (acc) begin
                    ir <= mem_rdata;
                    pc <= pc + ADDR_W'(4);
                end
                DECODE: begin
                    a <= rf[rs];
                    b <= rf[rt];
                    if (legal && op == OP_J) pc <= jt[ADDR_W-1:0];
                end
                EXEC: begin
                    aluout <= alu_res;
                    if (is_br && taken) pc <= pc + br_off[ADDR_W-1:0];
                end
                MEM: if (acc && op == OP_LW) mdr <= mem_rdata;
                // rf[0] is never written, so it keeps reading as zero
                WB: if (wa != 5'd0) rf[wa] <= wd;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: directed vector bench for mc_cpu with a wait-state memory model.
// A second instance with ADDR_W=8 starting at 0xFC exercises pc wrap-around.
module tb_mc_cpu;
    logic        Clk = 1'b0;
    logic        Clrn = 1'b0;
    logic        mem_req, mem_we, mem_ack, halt;
    logic [15:0] mem_addr, pc;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  state;
    logic        mem_req8, mem_we8, halt8;
    logic [7:0]  mem_addr8, pc8;
    logic [31:0] mem_wdata8;
    logic [2:0]  state8;
    logic [31:0] mem [256];
    int          waits = 0;
    int          wcnt = 0;
    int          errors = 0;
    int          checks = 0;

    mc_cpu #(.ADDR_W(16), .RESET_PC(32'h0)) dut (
        .Clk(Clk), .Clrn(Clrn), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
        .state(state), .halt(halt)
    );

    mc_cpu #(.ADDR_W(8), .RESET_PC(32'hFC)) dut8 (
        .Clk(Clk), .Clrn(Clrn), .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8),
        .mem_wdata(mem_wdata8), .mem_rdata(32'h0000_0020), .mem_ack(mem_req8), .pc(pc8),
        .state(state8), .halt(halt8)
    );

    always #5 Clk = ~Clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ack   = mem_req && (wcnt == waits);

    always @(posedge Clk) begin
        wcnt <= (!mem_req || mem_ack) ? 0 : wcnt + 1;
        if (mem_req && mem_ack && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  r;
        logic [31:0] exp;
        int          cyc;
        logic        chk_mem;
    } vec_t;

    vec_t v [16];

    function automatic logic [31:0] rr(input logic [5:0] fn, input logic [4:0] rd, rs, rt);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rt, rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_instr(output int c);
        logic left;
        left = 1'b0;
        c = 0;
        while (c < 100) begin
            @(negedge Clk);
            c++;
            if (state != 3'd0) left = 1'b1;
            else if (left) break;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n;
        n = 0;
        while (state !== s && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk(name, {29'h0, state}, {29'h0, s});
    endtask

    task automatic hold_reset();
        @(negedge Clk);
        Clrn = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Clrn = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        int c, n, bad;
        logic stable;
        v[0]  = '{it(6'h08, 5'd1, 5'd0, 16'h0005),       5'd1,  32'h0000_0005, 4, 1'b0};
        v[1]  = '{it(6'h08, 5'd2, 5'd0, 16'hFFFD),       5'd2,  32'hFFFF_FFFD, 4, 1'b0};
        v[2]  = '{rr(6'h20, 5'd3, 5'd1, 5'd2),           5'd3,  32'h0000_0002, 4, 1'b0};
        v[3]  = '{rr(6'h22, 5'd4, 5'd1, 5'd2),           5'd4,  32'h0000_0008, 4, 1'b0};
        v[4]  = '{rr(6'h25, 5'd5, 5'd1, 5'd2),           5'd5,  32'hFFFF_FFFD, 4, 1'b0};
        v[5]  = '{rr(6'h24, 5'd6, 5'd2, 5'd4),           5'd6,  32'h0000_0008, 4, 1'b0};
        v[6]  = '{rr(6'h2A, 5'd7, 5'd2, 5'd1),           5'd7,  32'h0000_0001, 4, 1'b0};
        v[7]  = '{rr(6'h2A, 5'd8, 5'd1, 5'd2),           5'd8,  32'h0000_0000, 4, 1'b0};
        v[8]  = '{it(6'h0C, 5'd9, 5'd2, 16'hF0F0),       5'd9,  32'h0000_F0F0, 4, 1'b0};
        v[9]  = '{it(6'h0D, 5'd10, 5'd0, 16'h8001),      5'd10, 32'h0000_8001, 4, 1'b0};
        v[10] = '{it(6'h08, 5'd11, 5'd0, 16'h8001),      5'd11, 32'hFFFF_8001, 4, 1'b0};
        v[11] = '{it(6'h2B, 5'd11, 5'd0, 16'h0080),      5'd0,  32'hFFFF_8001, 4, 1'b1};
        v[12] = '{it(6'h23, 5'd12, 5'd0, 16'h0083),      5'd12, 32'hFFFF_8001, 5, 1'b0};
        v[13] = '{it(6'h08, 5'd0, 5'd0, 16'h0007),       5'd0,  32'h0000_0000, 4, 1'b0};
        v[14] = '{rr(6'h20, 5'd5, 5'd0, 5'd0),           5'd5,  32'h0000_0000, 4, 1'b0};
        v[15] = '{rr(6'h22, 5'd14, 5'd0, 5'd1),          5'd14, 32'hFFFF_FFFB, 4, 1'b0};

        // Reset state, sampled between clock edges
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem[i] = v[i].ins;
        #12;
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_state", {29'h0, state}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_halt", {31'h0, halt}, 32'h0);
        chk("rst_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_pc8", {24'h0, pc8}, 32'hFC);
        chk("rst_req8", {31'h0, mem_req8}, 32'h0);
        release_reset();
        chk("req_after_rst", {31'h0, mem_req}, 32'h1);

        // Straight-line ALU / load / store program, zero wait states
        for (int i = 0; i < 16; i++) begin
            run_instr(c);
            chk($sformatf("cyc%0d", i), c, v[i].cyc);
            chk($sformatf("val%0d", i), v[i].chk_mem ? mem[8'h20] : dut.rf[v[i].r], v[i].exp);
        end

        // Store then load with three wait states per access
        hold_reset();
        waits = 3;
        mem[0]    = it(6'h23, 5'd1, 5'd0, 16'h0084);
        mem[1]    = {6'h02, 26'h4};
        mem[4]    = it(6'h2B, 5'd1, 5'd0, 16'h0008);
        mem[5]    = it(6'h23, 5'd4, 5'd0, 16'h0008);
        mem[6]    = {6'h02, 26'h6};
        mem[8'h21] = 32'hA5A5_A5A5;
        release_reset();
        run_instr(c);
        chk("lw_wait_cyc", c, 11);
        run_instr(c);
        chk("j_wait_cyc", c, 5);
        wait_state(3'd3, "sw_reach_mem");
        n = 0;
        stable = 1'b1;
        while (state == 3'd3 && n < 20) begin
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h8 || mem_wdata !== 32'hA5A5_A5A5) stable = 1'b0;
            n++;
            @(negedge Clk);
        end
        chk("sw_hold_cycles", n, 4);
        chk("sw_hold_stable", {31'h0, stable}, 32'h1);
        run_instr(c);
        chk("lw2_wait_cyc", c, 11);
        chk("lw_result", dut.rf[4], 32'hA5A5_A5A5);
        chk("sw_memory", mem[2], 32'hA5A5_A5A5);

        // Branches and jump, zero wait states
        hold_reset();
        waits = 0;
        mem[0] = {6'h02, 26'h4};
        mem[4] = it(6'h04, 5'd0, 5'd0, 16'hFFFF);
        release_reset();
        run_instr(c);
        chk("j_cyc", c, 2);
        chk("j_pc", {16'h0, pc}, 32'h10);
        run_instr(c);
        chk("beq_cyc", c, 3);
        chk("beq_taken_pc", {16'h0, pc}, 32'h10);
        mem[4] = it(6'h05, 5'd0, 5'd0, 16'h0005);
        run_instr(c);
        chk("bne_cyc", c, 3);
        chk("bne_nt_pc", {16'h0, pc}, 32'h14);
        mem[5] = {6'h02, 26'h40};
        mem[8'h40] = it(6'h08, 5'd1, 5'd0, 16'h0001);
        mem[8'h41] = it(6'h05, 5'd0, 5'd1, 16'hFFFE);
        run_instr(c);
        chk("j40_pc", {16'h0, pc}, 32'h100);
        run_instr(c);
        run_instr(c);
        chk("bne_taken_pc", {16'h0, pc}, 32'h100);
        mem[8'h41] = it(6'h04, 5'd0, 5'd1, 16'h0003);
        run_instr(c);
        run_instr(c);
        chk("beq_nt_pc", {16'h0, pc}, 32'h108);

        // Illegal opcode at 0x20 traps and stays halted
        hold_reset();
        mem[0] = {6'h02, 26'h8};
        mem[8] = 32'hFC00_0000;
        release_reset();
        run_instr(c);
        wait_state(3'd5, "halt_state");
        chk("halt_pc", {16'h0, pc}, 32'h24);
        bad = 0;
        repeat (100) begin
            @(negedge Clk);
            if (halt !== 1'b1 || mem_req !== 1'b0 || pc !== 16'h24) bad++;
        end
        chk("halt_hold", bad, 0);
        Clrn = 1'b0;
        #1;
        chk("halt_clr", {31'h0, halt}, 32'h0);
        chk("halt_clr_pc", {16'h0, pc}, 32'h0);

        // Reset pulsed during a waited store aborts it
        hold_reset();
        waits = 5;
        mem[0] = it(6'h2B, 5'd0, 5'd0, 16'h0080);
        mem[8'h20] = 32'h1234_5678;
        release_reset();
        wait_state(3'd3, "abort_reach_mem");
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_we_before", {31'h0, mem_we}, 32'h1);
        #2;
        Clrn = 1'b0;
        #1;
        chk("abort_req", {31'h0, mem_req}, 32'h0);
        chk("abort_we", {31'h0, mem_we}, 32'h0);
        chk("abort_state", {29'h0, state}, 32'h0);
        chk("abort_addr", {16'h0, mem_addr}, 32'h0);
        waits = 0;
        @(negedge Clk);
        chk("abort_mem", mem[8'h20], 32'h1234_5678);
        Clrn = 1'b1;
        @(negedge Clk);
        chk("refetch_req", {31'h0, mem_req}, 32'h1);
        chk("refetch_addr", {16'h0, mem_addr}, 32'h0);
        chk("wrap_addr8", {24'h0, mem_addr8}, 32'hFC);
        @(negedge Clk);
        chk("refetch_state", {29'h0, state}, 32'h1);
        chk("wrap_pc8", {24'h0, pc8}, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
